// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic tile scheduler and its serial IO.
package systolic_pkg;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_COMPUTE = 3'd3,
        S_DRAIN   = 3'd4,
        S_ADV     = 3'd5,
        S_FINISH  = 3'd6,
        S_ERR     = 3'd7
    } sched_state_t;

    // Geometry of the 4x4 array and the serial frame that carries one tile.
    localparam int TILE_DIM   = 4;
    localparam int ELEM_W     = 8;
    localparam int FRAME_BITS = TILE_DIM * TILE_DIM * ELEM_W;

endpackage

// File: rtl/tile_index_counter.sv
// Three-level nested (m, n, k) tile index counter; k is innermost, m outermost.
import systolic_pkg::*;

module tile_index_counter #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    input  logic [TW-1:0] m_tiles,
    input  logic [TW-1:0] n_tiles,
    input  logic [TW-1:0] k_tiles,
    output logic [TW-1:0] m_idx,
    output logic [TW-1:0] n_idx,
    output logic [TW-1:0] k_idx,
    output logic          k_last,
    output logic          job_last
);

    logic k_wrap_s;
    logic n_wrap_s;
    logic m_wrap_s;

    // Each level is on its last value when it equals count-1 (TW-bit compare).
    always_comb begin
        k_wrap_s = (k_idx == (k_tiles - TW'(1)));
        n_wrap_s = (n_idx == (n_tiles - TW'(1)));
        m_wrap_s = (m_idx == (m_tiles - TW'(1)));
        k_last   = k_wrap_s;
        job_last = k_wrap_s & n_wrap_s & m_wrap_s;
    end

    // Advance k; carry into n on k wrap, then into m on n wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idx <= '0;
            n_idx <= '0;
            k_idx <= '0;
        end else if (clear) begin
            m_idx <= '0;
            n_idx <= '0;
            k_idx <= '0;
        end else if (enable) begin
            if (k_wrap_s) begin
                k_idx <= '0;
                if (n_wrap_s) begin
                    n_idx <= '0;
                    m_idx <= m_wrap_s ? '0 : (m_idx + TW'(1));
                end else begin
                    n_idx <= n_idx + TW'(1);
                end
            end else begin
                k_idx <= k_idx + TW'(1);
            end
        end
    end

endmodule

// File: rtl/systolic_tile_scheduler.sv
// Sequences tiled matrix multiplies on the 4x4 serial systolic array:
// load A/B tiles, start the array, wait for done (with timeout), drain C.
import systolic_pkg::*;

module systolic_tile_scheduler #(
    parameter int TW      = 4,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [TW-1:0] cmd_m_tiles,
    input  logic [TW-1:0] cmd_n_tiles,
    input  logic [TW-1:0] cmd_k_tiles,
    input  logic          abort,
    output logic          load_req,
    output logic [TW-1:0] load_m_idx,
    output logic [TW-1:0] load_n_idx,
    output logic [TW-1:0] load_k_idx,
    input  logic          load_ack,
    output logic          arr_start,
    input  logic          arr_done,
    output logic          acc_first,
    output logic          acc_last,
    output logic          drain_req,
    input  logic          drain_ack,
    output logic          busy,
    output logic          job_done,
    output logic          err_timeout
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT - 1);

    sched_state_t  state_r;
    logic [TO_W-1:0] to_cnt_r;
    logic [TW-1:0] m_tiles_r;
    logic [TW-1:0] n_tiles_r;
    logic [TW-1:0] k_tiles_r;
    logic          idx_clear_s;
    logic          idx_enable_s;
    logic          k_last_s;
    logic          job_last_s;
    logic          zero_job_s;

    // Index counter control: reset on command accept, step once per ADV cycle.
    always_comb begin
        idx_clear_s  = (state_r == S_IDLE) & cmd_valid;
        idx_enable_s = (state_r == S_ADV) & ~abort;
        zero_job_s   = (cmd_m_tiles == TW'(0)) | (cmd_n_tiles == TW'(0)) |
                       (cmd_k_tiles == TW'(0));
    end

    tile_index_counter #(
        .TW (TW)
    ) u_idx (
        .clk      (clk),
        .rst      (rst),
        .clear    (idx_clear_s),
        .enable   (idx_enable_s),
        .m_tiles  (m_tiles_r),
        .n_tiles  (n_tiles_r),
        .k_tiles  (k_tiles_r),
        .m_idx    (load_m_idx),
        .n_idx    (load_n_idx),
        .k_idx    (load_k_idx),
        .k_last   (k_last_s),
        .job_last (job_last_s)
    );

    // Scheduler FSM; every output is registered and reflects the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            to_cnt_r    <= '0;
            m_tiles_r   <= '0;
            n_tiles_r   <= '0;
            k_tiles_r   <= '0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            load_req    <= 1'b0;
            arr_start   <= 1'b0;
            acc_first   <= 1'b0;
            acc_last    <= 1'b0;
            drain_req   <= 1'b0;
            job_done    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            arr_start <= 1'b0;
            job_done  <= 1'b0;
            if (abort && (state_r != S_IDLE)) begin
                // Cancel wins over any same-cycle ack or done; error flag untouched.
                state_r   <= S_IDLE;
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
                load_req  <= 1'b0;
                drain_req <= 1'b0;
                acc_first <= 1'b0;
                acc_last  <= 1'b0;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (cmd_valid) begin
                            m_tiles_r   <= cmd_m_tiles;
                            n_tiles_r   <= cmd_n_tiles;
                            k_tiles_r   <= cmd_k_tiles;
                            err_timeout <= 1'b0;
                            cmd_ready   <= 1'b0;
                            busy        <= 1'b1;
                            if (zero_job_s) begin
                                state_r  <= S_FINISH;
                                job_done <= 1'b1;
                            end else begin
                                state_r  <= S_LOAD;
                                load_req <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (load_ack) begin
                            state_r   <= S_START;
                            load_req  <= 1'b0;
                            arr_start <= 1'b1;
                            acc_first <= (load_k_idx == TW'(0));
                            acc_last  <= k_last_s;
                            to_cnt_r  <= '0;
                        end
                    end
                    S_START: begin
                        state_r   <= S_COMPUTE;
                        acc_first <= 1'b0;
                        acc_last  <= 1'b0;
                    end
                    S_COMPUTE: begin
                        // A done arriving on the limit cycle still counts as success.
                        if (arr_done) begin
                            if (k_last_s) begin
                                state_r   <= S_DRAIN;
                                drain_req <= 1'b1;
                            end else begin
                                state_r <= S_ADV;
                            end
                        end else if (to_cnt_r == TO_LIMIT) begin
                            state_r     <= S_ERR;
                            err_timeout <= 1'b1;
                        end else begin
                            to_cnt_r <= to_cnt_r + TO_W'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (drain_ack) begin
                            state_r   <= S_ADV;
                            drain_req <= 1'b0;
                        end
                    end
                    S_ADV: begin
                        if (job_last_s) begin
                            state_r  <= S_FINISH;
                            job_done <= 1'b1;
                        end else begin
                            state_r  <= S_LOAD;
                            load_req <= 1'b1;
                        end
                    end
                    S_FINISH, S_ERR: begin
                        state_r   <= S_IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                    default: begin
                        state_r   <= S_IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        load_req  <= 1'b0;
                        drain_req <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
